// File: rtl/if_fetch_queue.sv
// if_fetch_queue: IF->ID {pc, code} FIFO with flush and NOP bubble when empty; same-cycle bypass when FETCHQ_BYPASS_EN is defined
module if_fetch_queue #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_code,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_code,
  input  logic          out_ready,
  output logic [AW:0]   count
);
  logic [63:0] mem [DEPTH];
  logic [63:0] hd;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic empty, full, push, pop, wr, rd;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign in_ready = ~full;
  assign count = cnt;
  assign hd = mem[rp];
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
`ifdef FETCHQ_BYPASS_EN
  logic byp;
  assign byp = empty & in_valid & ~flush;
  assign out_valid = ~empty | byp;
  assign out_pc = ~empty ? hd[63:32] : byp ? in_pc : '0;
  assign out_code = ~empty ? hd[31:0] : byp ? in_code : '0;
  assign wr = push & ~(byp & out_ready);
  assign rd = pop & ~byp;
`else
  assign out_valid = ~empty;
  assign out_pc = out_valid ? hd[63:32] : '0;
  assign out_code = out_valid ? hd[31:0] : '0;
  assign wr = push;
  assign rd = pop;
`endif
  // storage write; contents after flush/reset are don't-care
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {in_pc, in_code};
  // pointers and occupancy; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr != rd) cnt <= wr ? cnt + 1'b1 : cnt - 1'b1;
    end
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Small instruction FIFO sitting directly downstream of the IF stage and upstream of ID.
- Decouples PC/IM fetch from ID stalls by buffering {PC, instruction word} pairs.
- Provides a valid/ready handshake on both sides and a single-cycle flush for branch redirects and CP0 exception/eret redirects.
- Presents a NOP bubble (code = 0, PC = 0) to ID whenever empty.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (branch redirect / exception / eret); synchronous.
- in_valid  input  1  IF presents a fetched instruction this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_code  input  32  instruction word from IM.
- in_ready  output  1  queue can accept; IF must hold its PC (stallPC) when low.
- out_valid  output  1  head entry valid for ID.
- out_pc  output  32  PC of head entry; 0 when not valid.
- out_code  output  32  instruction of head entry; 0 (sll $0,$0,0) when not valid.
- out_ready  input  1  ID consumes the head this cycle (ID not stalled).
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array {pc, code}; write pointer wp and read pointer rp, AW bits each, wrapping modulo DEPTH; occupancy register cnt, AW+1 bits.
- Derived signals: empty = (cnt == 0); full = (cnt == DEPTH).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = ~full, registered-state only; no combinational path from out_ready.
  - A push into a full queue is therefore refused even when a pop occurs the same cycle.
- out_valid = ~empty; out_pc/out_code = array[rp] when valid, else 0.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 (without the optional feature).
- Push only: array[wp] <= {in_pc, in_code}; wp <= wp+1; cnt <= cnt+1.
- Pop only: rp <= rp+1; cnt <= cnt-1.
- Push and pop in the same cycle (only possible when 0 < cnt < DEPTH): both pointers advance; cnt unchanged.
- Pointer wrap: DEPTH-1 -> 0 with no gap; order is strictly FIFO.
- Flush takes priority over push and pop:
  - wp <= 0, rp <= 0, cnt <= 0.
  - The in-flight in_valid word is dropped.
  - out_valid goes 0 on the next cycle; array contents are don't-care.
- Reset (including mid-operation), in priority order reset > flush > push/pop:
  - wp = rp = 0, cnt = 0.
  - out_valid = 0, out_pc = 0, out_code = 0, in_ready = 1, count = 0.
- in_valid while in_ready = 0: ignored; IF is responsible for holding the word.
- out_ready while empty: ignored; no pointer movement, no underflow.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined:
  - When the queue is empty, in_valid = 1 and flush = 0, the outputs forward the input in the same cycle: out_valid = 1, out_pc = in_pc, out_code = in_code.
  - If out_ready is also 1, the word is consumed directly and not written (push and pop cancel; pointers and cnt unchanged).
  - If out_ready is 0, the word is written normally.
- Not defined: strictly registered; minimum latency 1 cycle; outputs depend only on state.

Test Plan:
- Reset then idle -> out_valid = 0, out_code = 0, out_pc = 0, in_ready = 1, count = 0 for 3 cycles.
- Push PCs 0x3000, 0x3004, 0x3008, 0x300C with out_ready = 0 (DEPTH = 4) -> count = 4, in_ready = 0; a fifth push of 0x3010 is refused. Then raise out_ready -> out_pc sequence 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles, then out_valid = 0.
- Continuous streaming at cnt = 2 with in_valid = out_ready = 1 for 10 cycles -> count stays 2; pointers wrap; outputs are in-order PCs 0x3000 + 4k with no drops or duplicates.
- Fill 3 entries, then assert flush together with in_valid (pc 0x4180) and out_ready -> next cycle count = 0, out_valid = 0, out_code = 0; 0x4180 is not enqueued and no pop is recorded.
- Assert reset while count = 3 -> next cycle all outputs at reset values; a subsequent push of 0x3000 emerges first.
- With FETCHQ_BYPASS_EN, empty queue, in_valid = 1 (pc 0x3000, code 0x24010001), out_ready = 1 -> same-cycle out_valid = 1, out_code = 0x24010001; count remains 0. Without the macro -> out_valid = 0 that cycle, 1 the next.
